// File: rtl/sc_frame_gate_pkg.sv
// Shared types, default widths and helpers for the frame gate.
// The state encoding here is common to the top and the peak tracker.
package sc_frame_gate_pkg;

  typedef enum logic [2:0] {IDLE, SEARCH, PEAK, WAIT, FWD} state_t;

  localparam int DATA_W_DEF   = 32;
  localparam int METRIC_W_DEF = 32;
  localparam int CNT_W_DEF    = 16;

  // Offset and packet length of zero behave as one.
  function automatic logic [31:0] sat1(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/sc_frame_gate_peak_tracker.sv
// Peak tracker: tracks the running maximum, the offset countdown and the plateau length.
// It also decides when a peak is rejected, frozen into WAIT, or when the gate opens.
module sc_peak_tracker
  import sc_frame_gate_pkg::*;
#(
  parameter int METRIC_W = METRIC_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_peak,
  input  logic                in_wait,
  input  logic                start,
  input  logic                xfer,
  input  logic [METRIC_W-1:0] metric,
  input  logic [METRIC_W-1:0] threshold,
  input  logic [CNT_W-1:0]    offset,
  input  logic [CNT_W-1:0]    min_plateau,
  output logic [METRIC_W-1:0] peak,
  output logic                peak_done,
  output logic                fwd_start,
  output logic                reject
);

  logic [METRIC_W-1:0] thr_q, max_q;
  logic [CNT_W-1:0]    off_m1_q, min_q, cnt_q, plat_q, plat_inc, off_m1_live;
  logic                above, new_max, cnt_zero;

  assign above       = metric > thr_q;
  assign new_max     = above && (metric >= max_q);
  assign cnt_zero    = (cnt_q == '0);
  assign plat_inc    = (plat_q == '1) ? plat_q : plat_q + CNT_W'(1);
  assign off_m1_live = CNT_W'(sat1(32'(offset)) - 32'd1);
  assign peak        = max_q;

  // Qualifiers only; the top combines them with the transfer strobe.
  always_comb begin
    fwd_start = 1'b0;
    peak_done = 1'b0;
    reject    = 1'b0;
    if (in_peak) begin
      if (above)                fwd_start = !new_max && cnt_zero;
      else if (plat_q < min_q)  reject    = 1'b1;
      else if (cnt_zero)        fwd_start = 1'b1;
      else                      peak_done = 1'b1;
    end else if (in_wait) begin
      fwd_start = cnt_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q    <= '0;
      max_q    <= '0;
      off_m1_q <= '0;
      min_q    <= '0;
      cnt_q    <= '0;
      plat_q   <= '0;
    end else if (start) begin
      thr_q    <= threshold;
      min_q    <= min_plateau;
      off_m1_q <= off_m1_live;
      max_q    <= metric;
      cnt_q    <= off_m1_live;
      plat_q   <= CNT_W'(1);
    end else if (xfer && in_peak) begin
      if (new_max) begin
        max_q  <= metric;
        cnt_q  <= off_m1_q;
        plat_q <= plat_inc;
      end else if (above && !cnt_zero) begin
        cnt_q  <= cnt_q - CNT_W'(1);
        plat_q <= plat_inc;
      end else if (peak_done) begin
        cnt_q  <= cnt_q - CNT_W'(1);
      end
    end else if (xfer && in_wait && !cnt_zero) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sc_frame_gate.sv
// Frame gate behind the Schmidl-Cox metric: finds the metric peak and forwards one
// packet of samples starting a programmable offset after it, with AXI-Stream gating.
module sc_frame_gate
  import sc_frame_gate_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int METRIC_W = METRIC_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter bit ONE_SHOT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                arm,
  input  logic [METRIC_W-1:0] threshold,
  input  logic [CNT_W-1:0]    offset,
  input  logic [CNT_W-1:0]    packet_length,
  input  logic [CNT_W-1:0]    min_plateau,
  input  logic [METRIC_W-1:0] m_tdata,
  input  logic                m_tvalid,
  output logic                m_tready,
  input  logic [DATA_W-1:0]   i_tdata,
  input  logic                i_tvalid,
  output logic                i_tready,
  output logic [DATA_W-1:0]   o_tdata,
  output logic                o_tuser,
  output logic                o_tlast,
  output logic                o_tvalid,
  input  logic                o_tready,
  output logic [CNT_W-1:0]    det_count,
  output logic [METRIC_W-1:0] last_peak,
  output logic                busy
);

  localparam state_t HOME = ONE_SHOT ? IDLE : SEARCH;

  state_t              state, state_nxt;
  logic                run, gate, xfer, start, last;
  logic                in_peak, in_wait, in_fwd;
  logic [CNT_W-1:0]    len_q, fcnt_q;
  logic [METRIC_W-1:0] peak;
  logic                peak_done, fwd_start, reject;

  assign run     = !(reset || clear);
  assign in_peak = (state == PEAK);
  assign in_wait = (state == WAIT);
  assign in_fwd  = (state == FWD);

  // gate never depends on o_tready, so ready has no path back onto itself.
  assign gate     = in_fwd || fwd_start;
  assign xfer     = run && m_tvalid && i_tvalid && (o_tready || !gate);
  assign m_tready = xfer;
  assign i_tready = xfer;
  assign start    = xfer && (state == SEARCH) && (m_tdata > threshold);
  assign last     = fwd_start ? (len_q == CNT_W'(1)) : (fcnt_q == len_q - CNT_W'(1));

  assign o_tvalid = run && gate && m_tvalid && i_tvalid;
  assign o_tdata  = i_tdata;
  assign o_tuser  = o_tvalid && fwd_start;
  assign o_tlast  = o_tvalid && last;
  assign busy     = (state != SEARCH) && (state != IDLE);

  sc_peak_tracker #(
    .METRIC_W (METRIC_W),
    .CNT_W    (CNT_W)
  ) u_tracker (
    .clk         (clk),
    .reset       (!run),
    .in_peak     (in_peak),
    .in_wait     (in_wait),
    .start       (start),
    .xfer        (xfer),
    .metric      (m_tdata),
    .threshold   (threshold),
    .offset      (offset),
    .min_plateau (min_plateau),
    .peak        (peak),
    .peak_done   (peak_done),
    .fwd_start   (fwd_start),
    .reject      (reject)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (ONE_SHOT && arm) state_nxt = SEARCH;
      SEARCH: if (start) state_nxt = PEAK;
      PEAK, WAIT: begin
        if (xfer) begin
          if (reject)         state_nxt = SEARCH;
          else if (fwd_start) state_nxt = last ? HOME : FWD;
          else if (peak_done) state_nxt = WAIT;
        end
      end
      FWD:    if (xfer && last) state_nxt = HOME;
      default: state_nxt = HOME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      state     <= HOME;
      len_q     <= '0;
      fcnt_q    <= '0;
      det_count <= '0;
      last_peak <= '0;
    end else begin
      state <= state_nxt;
      if (start) len_q <= CNT_W'(sat1(32'(packet_length)));
      if (xfer && fwd_start) begin
        fcnt_q    <= CNT_W'(1);
        det_count <= det_count + CNT_W'(1);
        last_peak <= peak;
      end else if (xfer && in_fwd) begin
        fcnt_q <= fcnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/sc_frame_gate.md
Name: sc_frame_gate

Overview:
- Parametrised successor of the Schmidl-Cox detection stage.
- Consumes a lockstep pair of AXI-Stream inputs: the timing metric and the delayed sample stream.
- Finds the metric peak above a runtime threshold and rejects plateaus shorter than a minimum length.
- Forwards exactly packet_length samples, starting a programmable offset after the peak, with true AXI gating, regenerated tlast and a start-of-frame tuser flag. Sits between the metric calculator and the FFT/CP-removal chain.

Parameters:
- DATA_W, 32, sample width (packed I/Q).
- METRIC_W, 32, metric width, unsigned.
- CNT_W, 16, width of offset, length, plateau and statistics counters.
- ONE_SHOT, 0, 1 = disarm after each frame until arm is pulsed.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous soft clear, same effect as reset.
- arm  in  1  one-cycle pulse; re-arms the block when ONE_SHOT=1, ignored otherwise.
- threshold  in  METRIC_W  detection threshold; detection requires metric > threshold.
- offset  in  CNT_W  samples from the peak sample to the first forwarded sample; 0 is treated as 1.
- packet_length  in  CNT_W  number of samples forwarded per frame; 0 is treated as 1.
- min_plateau  in  CNT_W  minimum count of consecutive above-threshold metrics for a valid frame.
- m_tdata/m_tvalid/m_tready  in/in/out  METRIC_W/1/1  metric stream; m_tlast is ignored.
- i_tdata/i_tvalid/i_tready  in/in/out  DATA_W/1/1  sample stream; i_tlast is ignored.
- o_tdata/o_tuser/o_tlast/o_tvalid/o_tready  out/out/out/out/in  DATA_W/1/1/1/1  gated frame output; o_tuser marks the first sample of a frame.
- det_count  out  CNT_W  frames started; wraps on overflow.
- last_peak  out  METRIC_W  peak value of the most recent accepted frame.
- busy  out  1  high when the state is not SEARCH and not IDLE.

Behaviour:
- Transfer: xfer = m_tvalid & i_tvalid & (o_tready | !gate), where gate = "this sample is forwarded".
- m_tready = i_tready = xfer. Ready depends on valid, which is legal AXI; no combinational path from o_tready to itself.
- Outside the gate, samples are consumed and dropped with o_tvalid=0.
- Inside the gate: o_tvalid = m_tvalid & i_tvalid, o_tdata = i_tdata. Zero added latency.
- Reset/clear values:
  - state = SEARCH, or IDLE if ONE_SHOT.
  - All counters 0; det_count 0; last_peak 0.
  - During reset, both readies and o_tvalid are 0.
- threshold, offset, packet_length and min_plateau are latched on the SEARCH->PEAK transfer. Changes mid-frame do not affect the current frame.
- IDLE: no xfer gating; samples are consumed and dropped. arm -> SEARCH.
- SEARCH: xfer with metric > thr -> PEAK; max <= metric; cnt <= offset-1; plat <= 1.
- PEAK: on each xfer:
  - If metric > thr and metric >= max: max <= metric; cnt <= offset-1; plat++. On equal values, the later sample wins.
  - If metric > thr and metric < max:
    - cnt > 0: cnt--; plat++.
    - cnt == 0: this sample is gated, i.e. first forwarded. This covers a plateau longer than the offset.
  - If metric <= thr:
    - plat < min_plateau -> SEARCH. Spurious peak; det_count unchanged.
    - else if cnt == 0: gated, first forwarded.
    - else cnt--; -> WAIT.
- WAIT: on each xfer, metric is ignored.
  - cnt > 0: cnt--.
  - cnt == 0: gated, first forwarded.
- First forwarded sample (from PEAK or WAIT):
  - Asserts o_tuser=1.
  - det_count++; last_peak <= max; fcnt <= 1.
  - -> FWD, or straight back to SEARCH/IDLE if packet_length == 1, with o_tlast=1 on that same sample.
  - Net result: the first forwarded sample index is exactly peak_index + offset.
- FWD: gate=1.
  - Each xfer: fcnt++.
  - o_tlast = (fcnt == packet_length-1).
  - On the tlast transfer -> SEARCH, or IDLE when ONE_SHOT.
- Backpressure: o_tready=0 while gated stalls both inputs. State, counters and o_tdata are held; o_tvalid stays high.
- Simultaneous arm and reset: reset wins.
- Reset mid-FWD: frame aborted, no tlast emitted.

Decomposition:
- Package sc_frame_gate_pkg:
  - state enum {IDLE, SEARCH, PEAK, WAIT, FWD}.
  - Default widths.
  - Function sat1(x) implementing the 0 -> 1 clamp.
- One natural sub-module: sc_peak_tracker. It owns max, cnt, plat and the PEAK-state compare logic, and returns peak_done/fwd_start/reject.

Test Plan:
- thr=10, offset=4, len=3, min_plateau=2; metrics 0,12,15,11,5,5,5,5,5,5 -> peak at index 2; samples 6,7,8 forwarded; o_tuser on 6; o_tlast on 8; det_count=1; last_peak=15.
- Same config; metrics 0,20,0,0,... -> plateau 1 < 2, rejected; no o_tvalid ever; det_count=0.
- thr=10, offset=2, len=2, min_plateau=1; metrics 12,13,11,11,11 -> peak at index 1; samples 3,4 forwarded while the metric is still above threshold; then SEARCH.
- Equal max: metrics 15,15,0 with offset=1 -> first forwarded index 2 (peak at 1).
- Backpressure: o_tready low for 5 cycles mid-FWD -> both readies 0, o_tdata stable; after release the remaining count is exact and tlast lands on the last sample.
- ONE_SHOT=1: after one frame, a second qualifying peak produces no output until arm is pulsed. Reset asserted mid-FWD -> o_tvalid 0 the next cycle, state IDLE, det_count 0.
